// File: rtl/branch_redirect_pkg.sv
// branch_redirect_pkg: shared widths, PC constants and FSM state encoding for the branch redirect slice
package branch_redirect_pkg;
    localparam int FULLW = 32;
    localparam int PC_INC = 4;
    localparam int PC_AHEAD = 8;
    typedef enum logic {
        BR_RUN = 1'b0,
        BR_FLUSH = 1'b1
    } br_state_e;
endpackage

// File: rtl/branch_redirect_if.sv
// branch_redirect_if: decode-to-fetch branch interface; BRANCH_LINK_EN adds the link-register write port
interface branch_redirect_if #(
    parameter int FULLW = branch_redirect_pkg::FULLW
);
    logic stall_in;
    logic ib_in;
    logic dec_valid_in;
    logic cond_pass_in;
    logic [FULLW-1:0] bv_in;
    logic [FULLW-1:0] br_pc_in;
    logic [FULLW-1:0] pc_out;
    logic fetch_valid_out;
    logic flush_out;
    logic busy_out;
`ifdef BRANCH_LINK_EN
    logic link_in;
    logic lr_we_out;
    logic [FULLW-1:0] lr_data_out;
    modport master (
        output stall_in, ib_in, dec_valid_in, cond_pass_in, bv_in, br_pc_in, link_in,
        input pc_out, fetch_valid_out, flush_out, busy_out, lr_we_out, lr_data_out
    );
    modport slave (
        input stall_in, ib_in, dec_valid_in, cond_pass_in, bv_in, br_pc_in, link_in,
        output pc_out, fetch_valid_out, flush_out, busy_out, lr_we_out, lr_data_out
    );
`else
    modport master (
        output stall_in, ib_in, dec_valid_in, cond_pass_in, bv_in, br_pc_in,
        input pc_out, fetch_valid_out, flush_out, busy_out
    );
    modport slave (
        input stall_in, ib_in, dec_valid_in, cond_pass_in, bv_in, br_pc_in,
        output pc_out, fetch_valid_out, flush_out, busy_out
    );
`endif
endinterface

// File: rtl/branch_target.sv
// branch_target: branch target adder, br_pc + read-PC offset + byte offset, wrapping modulo 2^FULLW
module branch_target #(
    parameter int FULLW = branch_redirect_pkg::FULLW,
    parameter int PC_AHEAD = branch_redirect_pkg::PC_AHEAD
) (
    input logic [FULLW-1:0] br_pc,
    input logic [FULLW-1:0] bv,
    output logic [FULLW-1:0] target
);
    assign target = br_pc + FULLW'(PC_AHEAD) + bv;
endmodule

// File: rtl/branch_redirect.sv
// branch_redirect: owns the fetch PC, redirects on taken branches and squashes wrong-path fetches
// Optional macro BRANCH_LINK_EN adds the link-register write (lr_we_out/lr_data_out).
module branch_redirect #(
    parameter int FULLW = branch_redirect_pkg::FULLW,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int PC_AHEAD = branch_redirect_pkg::PC_AHEAD,
    parameter int FLUSH_CYCLES = 2
) (
    input logic clk,
    input logic reset,
    branch_redirect_if.slave bus
);
    import branch_redirect_pkg::*;
    localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
    br_state_e state;
    logic [CW-1:0] cnt;
    logic [FULLW-1:0] pc;
    logic [FULLW-1:0] target;
    logic fetch_valid;
    logic flush;
    logic take;
    branch_target #(.FULLW(FULLW), .PC_AHEAD(PC_AHEAD)) u_target (
        .br_pc(bus.br_pc_in),
        .bv(bus.bv_in),
        .target(target)
    );
    assign take = bus.ib_in & bus.dec_valid_in & bus.cond_pass_in & ~bus.stall_in & (state == BR_RUN);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BR_RUN;
            cnt <= '0;
            pc <= FULLW'(RESET_PC);
            fetch_valid <= 1'b1;
            flush <= 1'b0;
        end else begin
            flush <= 1'b0;
            if (take) begin
                state <= BR_FLUSH;
                cnt <= CW'(FLUSH_CYCLES - 1);
                pc <= target;
                fetch_valid <= 1'b0;
                flush <= 1'b1;
            end else if (!bus.stall_in) begin
                pc <= pc + FULLW'(PC_INC);
                if (state == BR_RUN || cnt == '0) begin
                    state <= BR_RUN;
                    fetch_valid <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
`ifdef BRANCH_LINK_EN
    logic lr_we;
    logic [FULLW-1:0] lr_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            lr_we <= 1'b0;
            lr_data <= '0;
        end else begin
            lr_we <= take & bus.link_in;
            if (take && bus.link_in) lr_data <= bus.br_pc_in + FULLW'(PC_INC);
        end
    end
    assign bus.lr_we_out = lr_we;
    assign bus.lr_data_out = lr_data;
`endif
    assign bus.pc_out = pc;
    assign bus.fetch_valid_out = fetch_valid;
    assign bus.flush_out = flush;
    assign bus.busy_out = state == BR_FLUSH;
endmodule

// File: tb/tb_branch_redirect.sv
// tb_branch_redirect: directed self-checking bench for branch_redirect (covers BRANCH_LINK_EN when defined)
module tb_branch_redirect;
    logic clk = 1'b0;
    logic reset;
    int n_cmp = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    branch_redirect_if bif ();
    branch_redirect dut (
        .clk(clk),
        .reset(reset),
        .bus(bif.slave)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic chk_all(input string tag, input logic [31:0] pc, input logic fv, input logic fl, input logic bz);
        chk({tag, ".pc"}, bif.pc_out, pc);
        chk({tag, ".valid"}, 32'(bif.fetch_valid_out), 32'(fv));
        chk({tag, ".flush"}, 32'(bif.flush_out), 32'(fl));
        chk({tag, ".busy"}, 32'(bif.busy_out), 32'(bz));
    endtask
    task automatic branch(input logic [31:0] br_pc, input logic [31:0] bv);
        bif.ib_in = 1'b1;
        bif.dec_valid_in = 1'b1;
        bif.cond_pass_in = 1'b1;
        bif.br_pc_in = br_pc;
        bif.bv_in = bv;
    endtask
    task automatic idle();
        bif.ib_in = 1'b0;
        bif.dec_valid_in = 1'b0;
        bif.cond_pass_in = 1'b0;
`ifdef BRANCH_LINK_EN
        bif.link_in = 1'b0;
`endif
    endtask
    initial begin
        reset = 1'b1;
        bif.stall_in = 1'b0;
        bif.bv_in = '0;
        bif.br_pc_in = '0;
        idle();
        tick();
        tick();
        chk_all("reset", 32'h0, 1, 0, 0);
`ifdef BRANCH_LINK_EN
        chk("reset.lr_we", 32'(bif.lr_we_out), 0);
        chk("reset.lr_data", bif.lr_data_out, 0);
`endif
        reset = 1'b0;
        tick(); chk_all("run1", 32'h4, 1, 0, 0);
        tick(); chk_all("run2", 32'h8, 1, 0, 0);
        tick(); chk_all("run3", 32'hC, 1, 0, 0);
        branch(32'h10, 32'h20);
        tick(); chk_all("fwd.tgt", 32'h38, 0, 1, 1);
        idle();
        tick(); chk_all("fwd.f1", 32'h3C, 0, 0, 1);
        tick(); chk_all("fwd.back", 32'h40, 1, 0, 0);
        tick(); chk_all("fwd.seq", 32'h44, 1, 0, 0);
        branch(32'h100, 32'hFFFF_FFF8);
        tick(); chk_all("bwd.tgt", 32'h100, 0, 1, 1);
        branch(32'h200, 32'h0);
        tick(); chk_all("bwd.ignore", 32'h104, 0, 0, 1);
        idle();
        tick(); chk_all("bwd.back", 32'h108, 1, 0, 0);
        branch(32'hFFFF_FFF8, 32'h8);
        tick(); chk_all("wrap.tgt", 32'h8, 0, 1, 1);
        idle();
        tick(); chk_all("wrap.f1", 32'hC, 0, 0, 1);
        tick(); chk_all("wrap.back", 32'h10, 1, 0, 0);
        branch(32'h80, 32'h40);
        bif.cond_pass_in = 1'b0;
        tick(); chk_all("nottaken", 32'h14, 1, 0, 0);
        bif.cond_pass_in = 1'b1;
        bif.dec_valid_in = 1'b0;
        tick(); chk_all("bubble", 32'h18, 1, 0, 0);
        idle();
        bif.stall_in = 1'b1;
        branch(32'h80, 32'h40);
        tick(); chk_all("run.stall", 32'h18, 1, 0, 0);
        bif.stall_in = 1'b0;
        branch(32'h40, 32'h10);
        tick(); chk_all("stl.tgt", 32'h58, 0, 1, 1);
        idle();
        bif.stall_in = 1'b1;
        tick(); chk_all("stl.s1", 32'h58, 0, 0, 1);
        tick(); chk_all("stl.s2", 32'h58, 0, 0, 1);
        tick(); chk_all("stl.s3", 32'h58, 0, 0, 1);
        bif.stall_in = 1'b0;
        tick(); chk_all("stl.f1", 32'h5C, 0, 0, 1);
        tick(); chk_all("stl.back", 32'h60, 1, 0, 0);
        branch(32'h0, 32'h100);
        tick(); chk_all("rst.tgt", 32'h108, 0, 1, 1);
        idle();
        reset = 1'b1;
        tick(); chk_all("rst.flush", 32'h0, 1, 0, 0);
        reset = 1'b0;
        tick(); chk_all("rst.run", 32'h4, 1, 0, 0);
`ifdef BRANCH_LINK_EN
        branch(32'h20, 32'h0);
        bif.link_in = 1'b1;
        tick();
        chk("bl.we", 32'(bif.lr_we_out), 1);
        chk("bl.data", bif.lr_data_out, 32'h24);
        chk("bl.pc", bif.pc_out, 32'h28);
        idle();
        tick();
        chk("bl.we_off", 32'(bif.lr_we_out), 0);
        tick();
        chk("bl.back", 32'(bif.fetch_valid_out), 1);
        branch(32'h60, 32'h0);
        bif.cond_pass_in = 1'b0;
        bif.link_in = 1'b1;
        tick();
        chk("blnt.we", 32'(bif.lr_we_out), 0);
        chk("blnt.data", bif.lr_data_out, 32'h24);
        idle();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
